program_memory: RTL
===================

# program_memory

Instruction-side responder for `cpu_4bit`. It holds a 16-entry program store and answers the CPU's `instruction_addr` with the addressed `instruction`. It is loaded over a valid/ready stream from the host/testbench side. While it is idle or loading, it holds the CPU off through `cpu_hold`, and releases it once a complete program is in place. It sits between the program source and the CPU at the top level.

## Interface
Parameters:
- `DEPTH`, 16: number of entries. Fixed by the 4-bit `instruction_addr`.
- `INSTR_W`, `$bits(instruction_t)`: width of a stored word.

Ports:
- `clk`  in  1  single clock; everything is sampled on its rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `instruction_addr`  in  4  CPU fetch address.
- `instruction`  out  `instruction_t`  program word at `instruction_addr`.
- `load_start`  in  1  pulse that begins a new program load.
- `load_valid`  in  1  `load_data` is valid this cycle.
- `load_data`  in  `INSTR_W`  program word to store.
- `load_last`  in  1  marks the final word of the program; qualified by `load_valid`.
- `load_ready`  out  1  block accepts a word this cycle.
- `cpu_hold`  out  1  active-high; top level uses it to keep the CPU in reset.
- `prog_len`  out  5  number of words accepted in the current or last load (0..16).
- `load_error`  out  1  sticky overflow flag: more than 16 words were offered.

## Operation
States:
- **IDLE.** The reset state.
  - `load_start` → LOAD.
- **LOAD.** `load_ready` = 1.
  - A beat is accepted when `load_valid & load_ready`. On acceptance: `mem[wr_ptr] <= load_data`, `wr_ptr++`, `prog_len <= wr_ptr+1`.
  - Accepted beat with `load_last` = 1 → RUN. This includes the 16th beat.
  - 16th beat accepted with `load_last` = 0 → IDLE and `load_error <= 1`. Written words remain and `cpu_hold` stays 1.
  - `load_start` is ignored while in LOAD.
- **RUN.** `cpu_hold` = 0 and `load_ready` = 0.
  - `load_start` → LOAD, which re-asserts `cpu_hold`.

Entering LOAD, on the cycle `load_start` is sampled:
- All 16 entries are cleared to 0 in parallel.
- `wr_ptr <= 0`, `prog_len <= 0`, `load_error <= 0`.
- Unloaded entries therefore read 0.

Read path:
- `instruction = mem[instruction_addr]` is combinational from the register array and is valid in every state.
- A write is visible on `instruction` the cycle after its accepting edge.

Outputs are registered, with these values after reset:
- state = IDLE, memory = all 0, `wr_ptr` = 0, `prog_len` = 0.
- `load_ready` = 0, `cpu_hold` = 1, `load_error` = 0.
- `instruction` = 0 for any address.

Boundary conditions:
- `load_valid` with `load_ready` = 0 (IDLE/RUN): the data is dropped and there is no state change.
- `load_start` with `load_valid` in IDLE: the start is taken and the beat is not.
- `load_last` without `load_valid`: ignored.
- `wr_ptr` never wraps. The overflow path exits LOAD before a 17th write.
- Reset low in any state, including mid-load: on the next edge all state returns to the reset values above and the memory is cleared.
- `instruction_addr` equal to `wr_ptr` during LOAD reads the old (cleared) value until the write edge.

## Timing
- `load_start` sampled at edge t → `load_ready` = 1 and `cpu_hold` = 1 from t+1. The first beat can be accepted at edge t+1.
- Back-to-back beats are accepted at one per cycle. `load_valid` gaps stall without loss.
- Last beat accepted at edge t+k → from t+k+1: `load_ready` = 0, `cpu_hold` = 0, `prog_len` final.
- `load_start` in RUN sampled at edge r → `cpu_hold` = 1 from r+1. The CPU therefore sees reset no later than one cycle after the request.
- Overflow at edge e → from e+1: `load_error` = 1, `load_ready` = 0, `cpu_hold` = 1.
- Read latency is 0 cycles, address to `instruction`.

## Test plan
- **Reset:** hold `reset` = 0 for 2 cycles and sweep all addresses. Expect `instruction` = 0 at every address, `cpu_hold` = 1, `load_ready` = 0, `prog_len` = 0, `load_error` = 0.
- **Basic load:** `load_start`, then 3 back-to-back beats 0xA1, 0xB2, 0xC3 with `load_last` on the 3rd. Expect:
  - `prog_len` = 3, `cpu_hold` = 0 one cycle after the 3rd accept.
  - Addresses 0–2 read 0xA1/0xB2/0xC3, addresses 3–15 read 0.
- **Back-pressure and gaps:** 4 beats with `load_valid` low for 2 cycles between each. Expect exactly 4 writes in order, `prog_len` = 4, and no spurious accepts.
- **Full and overflow:**
  - 16 beats with `load_last` on the 16th → RUN, `prog_len` = 16, `load_error` = 0.
  - Repeat without `load_last` → `load_error` = 1, `cpu_hold` = 1, IDLE.
  - A 17th offered beat is not accepted (`load_ready` = 0).
- **Reload from RUN:** after a program is running, pulse `load_start`. Expect `cpu_hold` = 1 next cycle, all entries read 0, `prog_len` = 0. Load 2 new words and check only they are present.
- **Reset mid-load:** assert `reset` after 5 of 8 beats. Expect all memory 0, IDLE, `load_ready` = 0. Beats offered during and after reset are ignored until a new `load_start`.

Source files
------------

// File: rtl/program_memory_if.sv
// Bundles the program-load stream and the CPU fetch port of program_memory.
// The master side is the host/CPU, the slave side is the program store.
interface program_memory_if #(
  parameter int INSTR_W = 8
);
  logic [3:0]         instruction_addr;
  logic [INSTR_W-1:0] instruction;
  logic               load_start;
  logic               load_valid;
  logic [INSTR_W-1:0] load_data;
  logic               load_last;
  logic               load_ready;
  logic               cpu_hold;
  logic [4:0]         prog_len;
  logic               load_error;

  modport master (
    output instruction_addr, load_start, load_valid, load_data, load_last,
    input  instruction, load_ready, cpu_hold, prog_len, load_error
  );

  modport slave (
    input  instruction_addr, load_start, load_valid, load_data, load_last,
    output instruction, load_ready, cpu_hold, prog_len, load_error
  );
endinterface

// File: rtl/program_memory.sv
// 16-entry program store for cpu_4bit: loaded over a valid/ready stream,
// read combinationally by the CPU, and holding the CPU off until a program is complete.
module program_memory #(
  parameter int DEPTH   = 16,
  parameter int INSTR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  program_memory_if.slave  pm
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  state_e             state_q;
  state_e             state_d;
  logic [INSTR_W-1:0] mem_q [DEPTH];
  logic [4:0]         wr_ptr_q;
  logic [4:0]         prog_len_q;
  logic               load_error_q;
  logic               load_ready_q;
  logic               load_ready_d;
  logic               cpu_hold_q;
  logic               cpu_hold_d;

  logic accept_s;
  logic start_take_s;
  logic overflow_s;

  assign accept_s     = (state_q == ST_LOAD) & pm.load_valid;
  assign start_take_s = (state_q != ST_LOAD) & pm.load_start;
  // The 16th beat without load_last ends the load before the pointer can wrap.
  assign overflow_s   = accept_s & ~pm.load_last & (wr_ptr_q == 5'(DEPTH - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (pm.load_start) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (accept_s && pm.load_last) begin
          state_d = ST_RUN;
        end else if (overflow_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_RUN: begin
        if (pm.load_start) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state, so the flags are registered.
  always_comb begin
    load_ready_d = 1'b0;
    cpu_hold_d   = 1'b1;
    if (state_d == ST_LOAD) begin
      load_ready_d = 1'b1;
    end else begin
      load_ready_d = 1'b0;
    end
    if (state_d == ST_RUN) begin
      cpu_hold_d = 1'b0;
    end else begin
      cpu_hold_d = 1'b1;
    end
  end

  // Registered handshake and status outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      load_ready_q <= 1'b0;
      cpu_hold_q   <= 1'b1;
      load_error_q <= 1'b0;
      prog_len_q   <= 5'd0;
      wr_ptr_q     <= 5'd0;
    end else begin
      load_ready_q <= load_ready_d;
      cpu_hold_q   <= cpu_hold_d;
      if (start_take_s) begin
        load_error_q <= 1'b0;
        prog_len_q   <= 5'd0;
        wr_ptr_q     <= 5'd0;
      end else if (accept_s) begin
        load_error_q <= load_error_q | overflow_s;
        prog_len_q   <= wr_ptr_q + 5'd1;
        wr_ptr_q     <= wr_ptr_q + 5'd1;
      end else begin
        load_error_q <= load_error_q;
        prog_len_q   <= prog_len_q;
        wr_ptr_q     <= wr_ptr_q;
      end
    end
  end

  // Program store: cleared on reset and at the start of every load.
  always_ff @(posedge clk) begin
    if (!reset || start_take_s) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (accept_s) begin
      mem_q[wr_ptr_q[3:0]] <= pm.load_data;
    end else begin
      mem_q <= mem_q;
    end
  end

  assign pm.instruction = mem_q[pm.instruction_addr];
  assign pm.load_ready  = load_ready_q;
  assign pm.cpu_hold    = cpu_hold_q;
  assign pm.prog_len    = prog_len_q;
  assign pm.load_error  = load_error_q;

endmodule
